// File: rtl/fetch_prefetch_unit_if.sv
// Instruction-memory beat port of the fetch prefetch unit: one request
// outstanding at a time, completed by ack (data or error).
interface fetch_prefetch_unit_if #(
    parameter int FETCH_BYTES = 4
);
    logic                     imem_req;
    logic [63:0]              imem_addr;
    logic                     imem_ack;
    logic [8*FETCH_BYTES-1:0] imem_data;
    logic                     imem_err;

    modport master (output imem_req, imem_addr, input imem_ack, imem_data, imem_err);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_data, imem_err);
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Y86-64 fetch stage: byte prefetch queue filled by aligned memory beats,
// combinational decode of the instruction at the queue head.
module fetch_prefetch_unit #(
    parameter int FETCH_BYTES = 4,
    parameter int QDEPTH      = 16,
    parameter int IMEM_BYTES  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fetch_prefetch_unit_if.master imem,
    input  logic                  redirect_valid,
    input  logic [63:0]           redirect_pc,
    input  logic                  F_stall,
    output logic                  f_valid,
    output logic [3:0]            f_icode,
    output logic [3:0]            f_ifun,
    output logic [3:0]            f_rA,
    output logic [3:0]            f_rB,
    output logic [63:0]           f_valC,
    output logic [63:0]           f_valP,
    output logic [63:0]           f_PC,
    output logic [63:0]           f_predPC,
    output logic [2:0]            f_stat
);
    localparam int CW  = $clog2(QDEPTH + 1);
    localparam int QW  = $clog2(QDEPTH);
    localparam int SKW = (FETCH_BYTES > 1) ? $clog2(FETCH_BYTES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;
    state_t state, state_nxt;

    logic [QDEPTH-1:0][7:0] q, q_nxt;
    logic [CW-1:0]          cnt, cnt_nxt, eff_cnt;
    logic [63:0]            head_pc, fetch_addr, req_addr, eff_addr, align_pc;
    logic [SKW-1:0]         skip;
    logic                   err_pending, halted;

    logic [3:0]  icode, ifun, len, pop_n;
    logic        ins_ok, has_regs, complete, show_err, consume, push_ok, issue;
    logic [63:0] valc_rr, valc_j, dec_valc, raw_valp;
    int          wpos;

    // ---------------- decode of the queue head ----------------
    assign icode = q[0][7:4];
    assign ifun  = q[0][3:0];

    always_comb begin
        len      = 4'd1;
        ins_ok   = 1'b1;
        has_regs = 1'b0;
        case (icode)
            4'h0, 4'h1, 4'h9:       len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: begin len = 4'd2;  has_regs = 1'b1; end
            4'h7, 4'h8:             len = 4'd9;
            4'h3, 4'h4, 4'h5:       begin len = 4'd10; has_regs = 1'b1; end
            default:                ins_ok = 1'b0;
        endcase
    end

    always_comb begin
        valc_rr = '0;
        valc_j  = '0;
        for (int i = 0; i < 8; i++) begin
            valc_rr[i*8 +: 8] = q[i+2];
            valc_j[i*8 +: 8]  = q[i+1];
        end
        case (icode)
            4'h3, 4'h4, 4'h5: dec_valc = valc_rr;
            4'h7, 4'h8:       dec_valc = valc_j;
            default:          dec_valc = '0;
        endcase
    end

    assign raw_valp = head_pc + 64'(len);
    assign complete = (cnt != '0) && (cnt >= CW'(len));
    // A pending fetch error only surfaces once the head can no longer complete.
    assign show_err = err_pending && !complete;
    assign f_valid  = !halted && (complete || err_pending);
    assign consume  = f_valid && !F_stall && !redirect_valid;
    assign pop_n    = (consume && !show_err) ? len : 4'd0;

    // Outputs read as zero whenever nothing is presented.
    always_comb begin
        f_icode  = '0;
        f_ifun   = '0;
        f_rA     = '0;
        f_rB     = '0;
        f_valC   = '0;
        f_valP   = '0;
        f_PC     = '0;
        f_predPC = '0;
        f_stat   = '0;
        if (f_valid) begin
            f_PC = head_pc;
            if (show_err) begin
                f_icode  = 4'h1;
                f_rA     = 4'hF;
                f_rB     = 4'hF;
                f_valP   = head_pc;
                f_predPC = head_pc;
                f_stat   = 3'b100;
            end else begin
                f_icode  = icode;
                f_ifun   = ifun;
                f_rA     = has_regs ? q[1][7:4] : 4'hF;
                f_rB     = has_regs ? q[1][3:0] : 4'hF;
                f_valC   = dec_valc;
                f_valP   = raw_valp;
                f_predPC = (icode == 4'h7 || icode == 4'h8) ? dec_valc : raw_valp;
                f_stat   = !ins_ok ? 3'b000 : (icode == 4'h0) ? 3'b011 : 3'b010;
            end
        end
    end

    // ---------------- request FSM ----------------
    // A redirect this cycle lets IDLE issue straight to the new aligned address.
    assign align_pc = redirect_pc & ~64'(FETCH_BYTES - 1);
    assign eff_addr = redirect_valid ? align_pc : fetch_addr;
    assign eff_cnt  = redirect_valid ? '0 : cnt;
    assign issue    = (redirect_valid || (!halted && !err_pending))
                   && (int'(eff_cnt) + FETCH_BYTES <= QDEPTH)
                   && (eff_addr < 64'(IMEM_BYTES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (issue) state_nxt = S_REQ;
            S_REQ:   if (imem.imem_ack) state_nxt = S_IDLE;
                     else if (redirect_valid) state_nxt = S_DROP;
            S_DROP:  if (imem.imem_ack) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        imem.imem_req  = (state != S_IDLE);
        imem.imem_addr = req_addr;
    end

    // ---------------- queue update ----------------
    assign push_ok = (state == S_REQ) && imem.imem_ack && !imem.imem_err && !redirect_valid;

    always_comb begin
        q_nxt   = q >> {pop_n, 3'b000};
        cnt_nxt = cnt - CW'(pop_n);
        wpos    = 0;
        for (int j = 0; j < FETCH_BYTES; j++) begin
            wpos = int'(cnt) - int'(pop_n) + j - int'(skip);
            if (push_ok && j >= int'(skip) && wpos < QDEPTH)
                q_nxt[QW'(wpos)] = imem.imem_data[j*8 +: 8];
        end
        if (push_ok)        cnt_nxt = cnt_nxt + CW'(FETCH_BYTES) - CW'(skip);
        if (redirect_valid) cnt_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q           <= '0;
            cnt         <= '0;
            head_pc     <= '0;
            fetch_addr  <= '0;
            req_addr    <= '0;
            skip        <= '0;
            err_pending <= 1'b0;
            halted      <= 1'b0;
        end else begin
            q   <= q_nxt;
            cnt <= cnt_nxt;
            if (state == S_IDLE && issue) req_addr <= eff_addr;
            if (redirect_valid) begin
                head_pc     <= redirect_pc;
                fetch_addr  <= align_pc;
                skip        <= SKW'(redirect_pc & 64'(FETCH_BYTES - 1));
                err_pending <= 1'b0;
                halted      <= 1'b0;
            end else begin
                if (consume) begin
                    head_pc <= f_valP;
                    if (f_stat != 3'b010) halted <= 1'b1;
                end
                if (push_ok) begin
                    fetch_addr <= fetch_addr + 64'(FETCH_BYTES);
                    skip       <= '0;
                end
                if ((state == S_REQ && imem.imem_ack && imem.imem_err)
                    || fetch_addr >= 64'(IMEM_BYTES))
                    err_pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a 1-cycle beat memory model.
module tb_fetch_prefetch_unit;
    localparam int FB  = 4;
    localparam int LAT = 1;

    logic        clk, rst_n;
    logic        redirect_valid, F_stall;
    logic [63:0] redirect_pc;
    logic        f_valid;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
    logic [63:0] f_valC, f_valP, f_PC, f_predPC;
    logic [2:0]  f_stat;

    fetch_prefetch_unit_if #(.FETCH_BYTES(FB)) mif ();

    fetch_prefetch_unit #(.FETCH_BYTES(FB), .QDEPTH(16), .IMEM_BYTES(1024)) dut (
        .clk(clk), .rst_n(rst_n), .imem(mif),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .F_stall(F_stall),
        .f_valid(f_valid), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
        .f_valC(f_valC), .f_valP(f_valP), .f_PC(f_PC), .f_predPC(f_predPC), .f_stat(f_stat)
    );

    logic [7:0]  mem [0:1023];
    logic        mem_hold;
    logic [63:0] err_addr;
    int          n_chk, n_fail, wcnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int max);
        int k;
        k = 0;
        while (!f_valid && k < max) begin tick(); k++; end
        chk({tag, "_valid"}, 64'(f_valid), 64'd1);
    endtask

    task automatic redirect(input logic [63:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    // Memory: acks LAT cycles after the request is first seen, one beat per request.
    initial begin
        mif.imem_ack  = 1'b0;
        mif.imem_err  = 1'b0;
        mif.imem_data = '0;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                mif.imem_ack = 1'b0;
                wcnt = 0;
            end else if (mif.imem_ack) begin
                mif.imem_ack = 1'b0;
            end else if (mif.imem_req && !mem_hold) begin
                if (wcnt == LAT) begin
                    for (int j = 0; j < FB; j++) begin
                        int a;
                        a = int'(mif.imem_addr[31:0]) + j;
                        mif.imem_data[j*8 +: 8] = (a < 1024) ? mem[a[9:0]] : 8'h00;
                    end
                    mif.imem_err = (mif.imem_addr == err_addr);
                    mif.imem_ack = 1'b1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [7:0] irmov [0:9];
        logic [7:0] jmp   [0:8];
        irmov = '{8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        jmp   = '{8'h70, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        n_chk = 0;
        n_fail = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h10;
        for (int i = 0; i < 10; i++) mem[i] = irmov[i];
        for (int i = 0; i < 9; i++) mem[16+i] = jmp[i];
        mem[35] = 8'h60; mem[36] = 8'h12; mem[37] = 8'h10; mem[38] = 8'h00;
        err_addr       = 64'h80;
        mem_hold       = 1'b1;
        rst_n          = 1'b0;
        F_stall        = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset state, first request, reset abandoning an outstanding request
        repeat (3) tick();
        chk("rst_valid", 64'(f_valid), 64'd0);
        chk("rst_req", 64'(mif.imem_req), 64'd0);
        chk("rst_stat", 64'(f_stat), 64'd0);
        chk("rst_pc", f_PC, 64'd0);
        rst_n = 1'b1;
        tick();
        chk("first_req", 64'(mif.imem_req), 64'd1);
        chk("first_addr", mif.imem_addr, 64'd0);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_req", 64'(mif.imem_req), 64'd0);
        chk("midrst_valid", 64'(f_valid), 64'd0);
        tick();
        mem_hold = 1'b0;
        rst_n    = 1'b1;
        tick();
        chk("rerst_req", 64'(mif.imem_req), 64'd1);
        chk("rerst_addr", mif.imem_addr, 64'd0);

        // irmovq $10,%rdx at 0
        wait_valid("irmovq", 30);
        chk("irm_icode", 64'(f_icode), 64'h3);
        chk("irm_rA", 64'(f_rA), 64'hF);
        chk("irm_rB", 64'(f_rB), 64'h2);
        chk("irm_valC", f_valC, 64'd10);
        chk("irm_valP", f_valP, 64'd10);
        chk("irm_pred", f_predPC, 64'd10);
        chk("irm_stat", 64'(f_stat), 64'b010);

        // Stall with a full queue, then one instruction per cycle
        repeat (20) tick();
        for (int i = 0; i < 6; i++) begin
            chk("full_req", 64'(mif.imem_req), 64'd0);
            chk("full_pc", f_PC, 64'd0);
            chk("full_valC", f_valC, 64'd10);
            tick();
        end
        F_stall = 1'b0;
        tick(); chk("run_pc0", f_PC, 64'h0A);
        tick(); chk("run_pc1", f_PC, 64'h0B);
        tick(); chk("run_pc2", f_PC, 64'h0C);

        // jmp 0x40 at 0x10
        F_stall = 1'b1;
        redirect(64'h10);
        wait_valid("jmp", 40);
        chk("jmp_pc", f_PC, 64'h10);
        chk("jmp_icode", 64'(f_icode), 64'h7);
        chk("jmp_rA", 64'(f_rA), 64'hF);
        chk("jmp_valC", f_valC, 64'h40);
        chk("jmp_valP", f_valP, 64'h19);
        chk("jmp_pred", f_predPC, 64'h40);

        // Redirect latency from IDLE with 1-cycle memory
        repeat (20) tick();
        redirect(64'h40);
        chk("lat_req", 64'(mif.imem_req), 64'd1);
        chk("lat_addr", mif.imem_addr, 64'h40);
        chk("lat_v1", 64'(f_valid), 64'd0);
        tick(); chk("lat_v2", 64'(f_valid), 64'd0);
        tick(); chk("lat_v3", 64'(f_valid), 64'd1);
        chk("lat_pc", f_PC, 64'h40);
        chk("lat_valP", f_valP, 64'h41);

        // Redirect to 0x23 while a request is outstanding
        mem_hold = 1'b1;
        repeat (2) tick();
        chk("out_req", 64'(mif.imem_req), 64'd1);
        chk("out_addr", mif.imem_addr, 64'h44);
        redirect(64'h23);
        chk("drop_req", 64'(mif.imem_req), 64'd1);
        chk("drop_addr", mif.imem_addr, 64'h44);
        chk("drop_valid", 64'(f_valid), 64'd0);
        mem_hold = 1'b0;
        begin
            int k;
            k = 0;
            while (!(mif.imem_req && mif.imem_addr == 64'h20) && k < 20) begin tick(); k++; end
            chk("redir_addr", mif.imem_addr, 64'h20);
        end
        wait_valid("addq", 20);
        chk("addq_pc", f_PC, 64'h23);
        chk("addq_icode", 64'(f_icode), 64'h6);
        chk("addq_rA", 64'(f_rA), 64'h1);
        chk("addq_rB", 64'(f_rB), 64'h2);
        chk("addq_valP", f_valP, 64'h25);
        chk("addq_stat", 64'(f_stat), 64'b010);

        // Run into halt, then resume with a redirect
        F_stall = 1'b0;
        tick(); chk("nop_pc", f_PC, 64'h25);
        tick(); chk("halt_pc", f_PC, 64'h26);
        chk("halt_stat", 64'(f_stat), 64'b011);
        tick(); chk("halted_valid", 64'(f_valid), 64'd0);
        repeat (5) tick();
        chk("halted_req", 64'(mif.imem_req), 64'd0);
        F_stall = 1'b1;
        redirect(64'h0);
        wait_valid("resume", 30);
        chk("resume_pc", f_PC, 64'h0);
        chk("resume_stat", 64'(f_stat), 64'b010);

        // Beat error on an unaligned redirect target
        redirect(64'h82);
        wait_valid("ierr", 30);
        chk("ierr_stat", 64'(f_stat), 64'b100);
        chk("ierr_icode", 64'(f_icode), 64'h1);
        chk("ierr_pc", f_PC, 64'h82);
        chk("ierr_valP", f_valP, 64'h82);
        F_stall = 1'b0;
        tick(); chk("ierr_halt", 64'(f_valid), 64'd0);

        // Fetch running off the end of instruction memory
        F_stall = 1'b1;
        redirect(64'h3FE);
        wait_valid("lim", 30);
        chk("lim_pc0", f_PC, 64'h3FE);
        F_stall = 1'b0;
        tick(); chk("lim_pc1", f_PC, 64'h3FF);
        chk("lim_stat1", 64'(f_stat), 64'b010);
        tick(); chk("lim_stat2", 64'(f_stat), 64'b100);
        chk("lim_pc2", f_PC, 64'h400);
        tick(); chk("lim_halt", 64'(f_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Next-generation Y86-64 fetch stage with a parametrised byte prefetch queue fed by a multi-byte, variable-latency instruction memory port over a req/ack handshake. The block decodes instruction length, extracts icode/ifun/rA/rB/valC, computes valP and predPC, and reports fetch status. It sits between the instruction memory and the F/D pipeline register. The PC-select logic drives its redirect input on mispredicted jumps and ret.

Parameters:
FETCH_BYTES, 4, bytes per memory beat; power of 2, range 1..8
QDEPTH, 16, queue capacity in bytes; must be >= 10+FETCH_BYTES
IMEM_BYTES, 1024, legal instruction address limit; addresses >= limit are errors

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request
imem_addr  out  64  beat address, FETCH_BYTES-aligned
imem_ack  in  1  data/err valid; completes request
imem_data  in  8*FETCH_BYTES  beat; bits[7:0] = lowest address
imem_err  in  1  beat error, qualified by imem_ack
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  64  new PC (any byte alignment)
F_stall  in  1  decode not accepting
f_valid  out  1  f_* outputs hold a complete instruction
f_icode, f_ifun, f_rA, f_rB  out  4 each  decoded fields (rA/rB=4'hF when absent)
f_valC  out  64  constant, little-endian
f_valP  out  64  f_PC + length
f_PC  out  64  address of presented instruction
f_predPC  out  64  valC for jxx/call, else valP
f_stat  out  3  [0] halt, [1] instruction valid, [2] imem error

Behaviour:
- Reset (async, rst_n=0): queue empty, head PC 0, fetch address 0, imem_req=0, f_valid=0, f_stat=0, all f_* = 0. A request outstanding at reset is abandoned. First request is issued the cycle after rst_n rises.
- Request FSM: IDLE, REQ, DROP.
- IDLE->REQ when not halted, free space >= FETCH_BYTES, and fetch address < IMEM_BYTES. Registered outputs; imem_req and imem_addr are held stable until imem_ack.
- REQ, ack: push FETCH_BYTES bytes and advance fetch address by FETCH_BYTES. On the first beat after a redirect, discard the leading (redirect_pc mod FETCH_BYTES) bytes. Return to IDLE. Only one request is outstanding at a time.
- Redirect while in REQ without ack: go to DROP. DROP waits for ack, discards the data, then returns to IDLE.
- Fetch address >= IMEM_BYTES, or an ack with imem_err=1: set err_pending and stop requesting.
- Length by icode: 0,1,9 -> 1; 2,6,A,B -> 2; 7,8 -> 9; 3,4,5 -> 10; others -> 1 with f_stat[1]=0.
- valC source: bytes 2..9 for icode 3/4/5; bytes 1..8 for icode 7/8; 0 otherwise.
- f_valid=1 when queue count >= length of the head byte. f_* are combinational from the queue head. f_stat is 3'b010 for normal instructions, 3'b011 for halt, 3'b000 for an invalid icode.
- err_pending with an incomplete head: f_valid=1, f_stat=3'b100, f_icode=1, f_valP=f_PC.
- Consume when f_valid && !F_stall && !redirect_valid: pop length bytes and set head PC to valP.
- Consuming an instruction with f_stat != 3'b010 enters HALTED: no requests issued, f_valid=0.
- Redirect (highest priority, takes effect next cycle): flush the queue, head PC = redirect_pc, fetch address = aligned redirect_pc, clear err_pending and HALTED. Consume is suppressed that cycle. An ack in the same cycle is dropped.
- Queue full: no request is issued. Queue empty: f_valid=0.
- Latency: with a 1-cycle memory, redirect at cycle N gives req at N+1, ack at N+2, and a 1-2 byte instruction valid at N+3.
- Address arithmetic is 64-bit wrap-around; count width is clog2(QDEPTH+1).

Test Plan:
1. Assert rst_n=0 mid-request, then release -> f_valid=0 and imem_req=0 during reset; imem_req=1 with imem_addr=0 one cycle after release.
2. Bytes 30 F2 0A 00 00 00 00 00 00 00 at address 0, FETCH_BYTES=4, 1-cycle memory -> after 3 beats f_valid=1, icode=3, rA=F, rB=2, valC=10, valP=10, predPC=10, f_stat=3'b010.
3. Bytes 70 40 00 00 00 00 00 00 00 at 0x10 -> icode=7, valC=0x40, valP=0x19, predPC=0x40.
4. Redirect to 0x23 while a request is outstanding -> stale beat dropped, next imem_addr=0x20, first f_PC=0x23, 3 leading bytes discarded.
5. F_stall held for 6 cycles with queue full -> f_* stable, imem_req stays 0; release -> one instruction consumed per cycle.
6. Byte 00 at head, consumed -> f_stat=3'b011 then HALTED, imem_req=0, f_valid=0; redirect to 0 resumes. imem_err on a beat -> f_stat=3'b100.
